// File: rtl/nway_tlc.sv
// N-approach round-robin traffic-light controller: green, yellow and all-red per approach.
// Define TLC_SKIP_EN to skip approaches whose req bit is clear at the all-red exit.
module nway_tlc #(
    parameter int N_WAY    = 4,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_WAY-1:0]           req,
    output logic [2*N_WAY-1:0]         lamp,
    output logic [$clog2(N_WAY)-1:0]   cur_way,
    output logic [1:0]                 phase
);

    localparam int WW = $clog2(N_WAY);
    localparam longint MAX_T = longint'(1) << CNT_W;
    localparam logic [CNT_W-1:0] G_LD = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] Y_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] A_LD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] T_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] T_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WW-1:0] LAST_WAY = WW'(N_WAY - 1);
    localparam logic [WW-1:0] FIRST_WAY = {WW{1'b0}};
    localparam logic [WW-1:0] WAY_ONE = {{(WW-1){1'b0}}, 1'b1};
    localparam logic [2*N_WAY-1:0] ALL_RED_L = {N_WAY{2'b10}};

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_e;

    generate
        if (N_WAY < 2 || N_WAY > 16) begin : g_bad_nway
            $error("nway_tlc: N_WAY must be in 2..16");
        end
        if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cntw
            $error("nway_tlc: CNT_W out of range");
        end
        if (GREEN_T < 1 || longint'(GREEN_T) > MAX_T) begin : g_bad_green
            $error("nway_tlc: GREEN_T must be in 1..2^CNT_W");
        end
        if (YELLOW_T < 1 || longint'(YELLOW_T) > MAX_T) begin : g_bad_yellow
            $error("nway_tlc: YELLOW_T must be in 1..2^CNT_W");
        end
        if (ALLRED_T < 1 || longint'(ALLRED_T) > MAX_T) begin : g_bad_allred
            $error("nway_tlc: ALLRED_T must be in 1..2^CNT_W");
        end
    endgenerate

    phase_e             state_r;
    logic [WW-1:0]      way_r;
    logic [CNT_W-1:0]   tmr_r;
    logic [2*N_WAY-1:0] lamp_r;
    logic [WW-1:0]      next_way_s;
    logic               found_s;

    // Every approach RED except `w`, which shows `code`.
    function automatic logic [2*N_WAY-1:0] lamp_for(input logic [WW-1:0] w, input logic [1:0] code);
        logic [2*N_WAY-1:0] v;
        v = ALL_RED_L;
        for (int i = 0; i < N_WAY; i++) begin
            if (i == int'(w)) begin
                v[2*i +: 2] = code;
            end else begin
                v[2*i +: 2] = 2'b10;
            end
        end
        return v;
    endfunction

`ifdef TLC_SKIP_EN
    logic [WW-1:0] idx_s;

    // Demand search: cur_way+1 upward with wrap, cur_way itself checked last.
    always_comb begin
        next_way_s = way_r;
        found_s    = 1'b0;
        idx_s      = way_r;
        for (int k = 0; k < N_WAY; k++) begin
            idx_s = (idx_s == LAST_WAY) ? FIRST_WAY : idx_s + WAY_ONE;
            if (!found_s && req[idx_s]) begin
                found_s    = 1'b1;
                next_way_s = idx_s;
            end else begin
                found_s    = found_s;
            end
        end
    end
`else
    logic req_unused_s;
    assign req_unused_s = ^req;

    // Fixed rotation with explicit wrap so non-power-of-two counts work.
    always_comb begin
        found_s = 1'b1;
        if (way_r == LAST_WAY) begin
            next_way_s = FIRST_WAY;
        end else begin
            next_way_s = way_r + WAY_ONE;
        end
    end
`endif

    // Phase FSM; lamp code is registered alongside the state so both change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= PH_ALLRED;
            way_r   <= LAST_WAY;
            tmr_r   <= A_LD;
            lamp_r  <= ALL_RED_L;
        end else begin
            case (state_r)
                PH_ALLRED: begin
                    if (tmr_r == T_ZERO) begin
                        if (found_s) begin
                            state_r <= PH_GREEN;
                            way_r   <= next_way_s;
                            tmr_r   <= G_LD;
                            lamp_r  <= lamp_for(next_way_s, 2'b00);
                        end else begin
                            tmr_r   <= T_ZERO;
                        end
                    end else begin
                        tmr_r <= tmr_r - T_ONE;
                    end
                end
                PH_GREEN: begin
                    if (tmr_r == T_ZERO) begin
                        state_r <= PH_YELLOW;
                        tmr_r   <= Y_LD;
                        lamp_r  <= lamp_for(way_r, 2'b01);
                    end else begin
                        tmr_r <= tmr_r - T_ONE;
                    end
                end
                PH_YELLOW: begin
                    if (tmr_r == T_ZERO) begin
                        state_r <= PH_ALLRED;
                        tmr_r   <= A_LD;
                        lamp_r  <= ALL_RED_L;
                    end else begin
                        tmr_r <= tmr_r - T_ONE;
                    end
                end
                default: begin
                    state_r <= PH_ALLRED;
                    tmr_r   <= A_LD;
                    lamp_r  <= ALL_RED_L;
                end
            endcase
        end
    end

    assign lamp    = lamp_r;
    assign cur_way = way_r;
    assign phase   = state_r;

endmodule

// File: tb/tb_nway_tlc.sv
// Scoreboard bench for nway_tlc: a default 4-way instance and a 3-way 1/1/1 instance.
module tb_nway_tlc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req4 = 4'b0000;
    logic [2:0] req3 = 3'b000;
    logic [7:0] lamp4;
    logic [1:0] cur_way4;
    logic [1:0] phase4;
    logic [5:0] lamp3;
    logic [1:0] cur_way3;
    logic [1:0] phase3;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] ph;
        int         way;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    nway_tlc u4 (
        .clk(clk), .rst(rst), .req(req4),
        .lamp(lamp4), .cur_way(cur_way4), .phase(phase4)
    );

    nway_tlc #(.N_WAY(3), .GREEN_T(1), .YELLOW_T(1), .ALLRED_T(1)) u3 (
        .clk(clk), .rst(rst), .req(req3),
        .lamp(lamp3), .cur_way(cur_way3), .phase(phase3)
    );

    function automatic logic [7:0] mk(input int n, input int way, input logic [1:0] ph);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < n; i++)
            v[2*i +: 2] = (ph != 2'b10 && i == way) ? ph : 2'b10;
        return v;
    endfunction

    task automatic push_service(input int sel, input int way, input int g, input int y, input int a);
        exp_t e;
        e.way = way;
        for (int c = 0; c < g + y + a; c++) begin
            e.ph = (c < g) ? 2'b00 : (c < g + y) ? 2'b01 : 2'b10;
            if (sel == 4) q4.push_back(e);
            else q3.push_back(e);
        end
    endtask

    task automatic push_idle(input int way, input int n);
        exp_t e;
        e.way = way;
        e.ph  = 2'b10;
        for (int c = 0; c < n; c++) q4.push_back(e);
    endtask

    // Advance one clock, drain one scoreboard entry per instance and check the lamp invariant.
    task automatic step();
        exp_t e;
        logic [7:0] el;
        int nr4, nr3;
        logic b11;
        @(posedge clk);
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            el = mk(4, e.way, e.ph);
            vectors++;
            if (lamp4 !== el || phase4 !== e.ph || cur_way4 !== 2'(e.way)) begin
                miscompares++;
                $display("FAIL seq4 t=%0t: lamp=%b phase=%b way=%0d, want lamp=%b phase=%b way=%0d",
                         $time, lamp4, phase4, cur_way4, el, e.ph, e.way);
            end
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            el = mk(3, e.way, e.ph);
            vectors++;
            if (lamp3 !== el[5:0] || phase3 !== e.ph || cur_way3 !== 2'(e.way)) begin
                miscompares++;
                $display("FAIL seq3 t=%0t: lamp=%b phase=%b way=%0d, want lamp=%b phase=%b way=%0d",
                         $time, lamp3, phase3, cur_way3, el[5:0], e.ph, e.way);
            end
        end
        nr4 = 0; nr3 = 0; b11 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lamp4[2*i +: 2] != 2'b10) nr4++;
            if (lamp4[2*i +: 2] == 2'b11) b11 = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (lamp3[2*i +: 2] != 2'b10) nr3++;
            if (lamp3[2*i +: 2] == 2'b11) b11 = 1'b1;
        end
        vectors++;
        if (nr4 > 1 || nr3 > 1 || b11 !== 1'b0) begin
            miscompares++;
            $display("FAIL invariant t=%0t: nonred4=%0d nonred3=%0d code11=%b, want <=1 <=1 0",
                     $time, nr4, nr3, b11);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q4.delete();
        q3.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (lamp4 !== 8'b10101010 || phase4 !== 2'b10 || cur_way4 !== 2'd3) begin
            miscompares++;
            $display("FAIL reset4: lamp=%b phase=%b way=%0d, want 10101010 10 3", lamp4, phase4, cur_way4);
        end
        vectors++;
        if (lamp3 !== 6'b101010 || phase3 !== 2'b10 || cur_way3 !== 2'd2) begin
            miscompares++;
            $display("FAIL reset3: lamp=%b phase=%b way=%0d, want 101010 10 2", lamp3, phase3, cur_way3);
        end
        rst = 1'b0;
        q4.delete();
        q3.delete();
    endtask

    task automatic test_rotation();
        do_reset();
        for (int k = 0; k < 8; k++) push_service(4, k % 4, 8, 2, 1);
        for (int k = 0; k < 30; k++) push_service(3, k % 3, 1, 1, 1);
        for (int c = 0; c < 90; c++) begin
`ifdef TLC_SKIP_EN
            req4 = 4'b1111;
            req3 = 3'b111;
`else
            req4 = 4'($urandom_range(0, 15));
            req3 = 3'($urandom_range(0, 7));
`endif
            step();
        end
    endtask

    task automatic test_reset_mid_green();
        exp_t e;
        req4 = 4'b1111;
        req3 = 3'b111;
        do_reset();
        push_service(4, 0, 8, 2, 1);
        push_service(4, 1, 8, 2, 1);
        e.way = 2;
        e.ph  = 2'b00;
        for (int c = 0; c < 3; c++) q4.push_back(e);
        for (int c = 0; c < 25; c++) step();
        q3.delete();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (lamp4 !== 8'b10101010 || phase4 !== 2'b10 || cur_way4 !== 2'd3) begin
            miscompares++;
            $display("FAIL async_rst: lamp=%b phase=%b way=%0d, want 10101010 10 3", lamp4, phase4, cur_way4);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        q3.delete();
        push_service(4, 0, 8, 2, 1);
        for (int c = 0; c < 11; c++) step();
    endtask

`ifdef TLC_SKIP_EN
    task automatic test_skip();
        req4 = 4'b0000;
        req3 = 3'b000;
        do_reset();
        push_idle(3, 20);
        for (int c = 0; c < 20; c++) step();
        req4 = 4'b0100;
        push_service(4, 2, 8, 2, 1);
        for (int c = 0; c < 3; c++) step();
        req4 = 4'b1000;
        push_service(4, 3, 8, 2, 1);
        push_service(4, 3, 8, 2, 1);
        for (int c = 0; c < 30; c++) step();
        req4 = 4'b0010;
        push_service(4, 1, 8, 2, 1);
        push_service(4, 2, 8, 2, 1);
        push_service(4, 3, 8, 2, 1);
        for (int c = 0; c < 3; c++) step();
        req4 = 4'b0001;
        for (int c = 0; c < 2; c++) step();
        req4 = 4'b1111;
        for (int c = 0; c < 28; c++) step();
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_reset_mid_green();
`ifdef TLC_SKIP_EN
        test_skip();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
